rom_burst_reader: RTL and testbench

//  Burst read sequencer directly upstream of the synchronous ROM. Accepts a
//  (base, length) command, drives the ROM addr/enable ports, captures the
//  1-cycle-latency read data and presents it as a valid/ready word stream.

---
 rtl/rom_burst_pkg.sv | 13 +
 rtl/rom_burst_buf.sv | 70 +++++++
 rtl/rom_burst_reader.sv | 155 +++++++++++++++
 tb/tb_rom_burst_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_burst_pkg.sv
// Shared definitions for the ROM burst reader: FSM state encoding and buffer depth.
package rom_burst_pkg;

  localparam int unsigned BUF_DEPTH = 2;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t READ  = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/rom_burst_buf.sv
// Two-entry FIFO holding {last, data} words between the ROM capture stage and
// the output stream. Push on a full buffer is accepted only alongside a pop.
module rom_burst_buf
  import rom_burst_pkg::*;
#(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [BUF_DEPTH];
  logic [W-1:0] mem_d [BUF_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full      = (count_q == 2'(BUF_DEPTH));
  assign empty     = (count_q == 2'd0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst read sequencer in front of a 1-cycle-latency synchronous ROM.
// Accepts (base, len), issues ROM reads under buffer credit, and streams the
// words out through a 2-entry buffer with valid/ready handshaking.
// Optional feature: define CHECKSUM_EN to add the burst_csum output.
module rom_burst_reader
  import rom_burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] burst_csum
`endif
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic                  inflight_q, inflight_d;
  logic                  infl_last_q, infl_last_d;

  logic [DATA_WIDTH:0]   buf_head;
  logic                  buf_full, buf_empty;
  logic [1:0]            buf_count;
  logic                  pop, issue, last_issue;
  logic [2:0]            avail;

  rom_burst_buf #(.W(DATA_WIDTH + 1)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({infl_last_q, rom_data}),
    .pop       (pop),
    .head_data (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign out_valid = !buf_empty;
  assign out_data  = buf_head[DATA_WIDTH-1:0];
  assign out_last  = buf_head[DATA_WIDTH] && !buf_empty;
  assign pop       = out_valid && out_ready;
  assign rom_addr  = base_q + issued_q[ADDR_WIDTH-1:0];
  assign rom_en    = issue;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign cmd_ready = (state_q == IDLE);

  // Issue credit: free slots (a same-cycle pop frees one) minus the read in flight.
  always_comb begin
    avail      = 3'(BUF_DEPTH) - {1'b0, buf_count} + {2'b0, pop} - {2'b0, inflight_q};
    issue      = (state_q == READ) && (avail != 3'd0) && !(buf_full && !pop);
    last_issue = issue && (issued_q == len_q - LEN_WIDTH'(1));
  end

  // Burst FSM and address/length bookkeeping.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issued_q;
    inflight_d  = issue;
    infl_last_d = last_issue;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          base_d   = cmd_base;
          len_d    = cmd_len;
          issued_d = '0;
          state_d  = (cmd_len != '0) ? READ : DONE;
        end
      end
      READ: begin
        if (issue) begin
          issued_d = issued_q + LEN_WIDTH'(1);
        end
        if (last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The final pop counts as drained so done lands the cycle after it.
        if (!inflight_q && (buf_empty || (buf_count == 2'd1 && pop))) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
    end
  end

`ifdef CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  assign burst_csum = csum_q;

  // XOR of delivered words, restarted on each command accept.
  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && cmd_valid) begin
      csum_d = '0;
    end else if (pop) begin
      csum_d = csum_q ^ out_data;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed self-checking bench for rom_burst_reader with a behavioural
// 1-cycle-latency ROM. Define CHECKSUM_EN to also exercise burst_csum.
module tb_rom_burst_reader;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_base;
  logic [8:0]  cmd_len;
  logic [7:0]  rom_addr;
  logic        rom_en;
  logic [31:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef CHECKSUM_EN
  logic [31:0] burst_csum;
`endif

  int unsigned n_cmp;
  int unsigned n_err;

  logic [31:0] rom_mem [256];
  logic [31:0] exp_data [$];
  logic [7:0]  exp_addr [$];

  rom_burst_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LEN_WIDTH(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .rom_addr  (rom_addr),
    .rom_en    (rom_en),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef CHECKSUM_EN
    ,
    .burst_csum(burst_csum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data one cycle after enable, junk otherwise.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
    else        rom_data <= 32'hBAD0_BAD0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rom_en"},    rom_en,    0);
    check({tag, "_rom_addr"},  rom_addr,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
  endtask

  // Runs one command; exp_addr/exp_data hold the hand-computed expectations.
  task automatic burst(input logic [7:0] base, input logic [8:0] len,
                       input int unsigned stall_n, input int unsigned junk_n);
    int unsigned c, n_iss, n_del, stall_left, st_seen, last_hs, done_c;
    bit done_seen, stalled_prev, ov_seen;
    logic [31:0] pd;
    logic pl;
    n_iss = 0; n_del = 0; stall_left = 0; st_seen = 0; last_hs = 0; done_c = 0;
    done_seen = 0; stalled_prev = 0; ov_seen = 0; pd = '0; pl = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_base = base; cmd_len = len; out_ready = 1'b1;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    c = 1;
    if (junk_n > 0) begin
      cmd_valid = 1'b1; cmd_base = 8'h77; cmd_len = 9'h1FF;
    end else begin
      cmd_valid = 1'b0;
    end
    while (!done_seen && c < 200) begin
      @(negedge clk);
      if (c == 1) begin
        check("busy_after_accept", busy, 1);
        check("first_rom_en", rom_en, len != 0);
      end
      if (c <= junk_n) check("cmd_ready_busy", cmd_ready, 0);
      if (rom_en) begin
        check("extra_issue", n_iss < len, 1);
        if (n_iss < len) check("rom_addr", rom_addr, exp_addr[n_iss]);
        n_iss++;
      end
      if (out_valid && !ov_seen) begin
        ov_seen = 1;
        check("first_out_latency", c, 3);
      end
      if (out_valid && stalled_prev) begin
        check("stall_data_stable", out_data, pd);
        check("stall_last_stable", out_last, pl);
      end
      stalled_prev = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      if (!out_ready) begin
        st_seen++;
        check("stall_occupancy_le2", (n_iss - n_del) <= 2, 1);
        if (st_seen == stall_n) check("stall_occupancy_full", n_iss - n_del, 2);
      end
      if (out_valid && out_ready) begin
        check("extra_word", n_del < len, 1);
        if (n_del < len) begin
          check("out_data", out_data, exp_data[n_del]);
          check("out_last", out_last, n_del == len - 1);
        end
        if (n_del > 0 && stall_n == 0) check("back_to_back", c, last_hs + 1);
        last_hs = c;
        n_del++;
        if (n_del == 1 && stall_n > 0) stall_left = stall_n;
      end
      if (done) begin
        done_seen = 1;
        done_c = c;
      end
      @(posedge clk); #1;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (c + 1 > junk_n) cmd_valid = 1'b0;
      c++;
    end
    cmd_valid = 1'b0;
    check("done_seen", done_seen, 1);
    check("words_delivered", n_del, len);
    check("words_issued", n_iss, len);
    check("out_valid_seen", ov_seen, len != 0);
    if (len == 0) check("empty_done_cycle", done_c, 1);
    else          check("done_after_last", done_c, last_hs + 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_again", cmd_ready, 1);
  endtask

  initial begin
    int unsigned hs;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; out_ready = 1'b1;
    for (int i = 0; i < 256; i++) rom_mem[i] = 32'hA5A5_0000 | 32'(i);
    rom_mem[8'h00] = 32'hDEAD_BEEF;
    rom_mem[8'h01] = 32'h1234_5678;
    rom_mem[8'h02] = 32'hABCD_EF01;
    rom_mem[8'hFE] = 32'h1111_00FE;
    rom_mem[8'hFF] = 32'h2222_00FF;
    rom_mem[8'h20] = 32'h3000_0020;
    rom_mem[8'h21] = 32'h3000_0021;
    rom_mem[8'h22] = 32'h3000_0022;
    rom_mem[8'h23] = 32'h3000_0023;
    rom_mem[8'h24] = 32'h3000_0024;
    rom_mem[8'h30] = 32'h0F0F_0F0F;
    rom_mem[8'h31] = 32'h00FF_00FF;
    rom_mem[8'h40] = 32'h4444_0040;
    rom_mem[8'h41] = 32'h4444_0041;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
`ifdef CHECKSUM_EN
    check("reset_csum", burst_csum, 0);
`endif
    rst_n = 1'b1;

    // 1: three words back to back from base 0
    exp_addr = '{8'h00, 8'h01, 8'h02};
    exp_data = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hABCD_EF01};
    burst(8'h00, 9'd3, 0, 0);

    // 2: address wrap FE,FF,00,01 with commands presented while busy
    exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_data = '{32'h1111_00FE, 32'h2222_00FF, 32'hDEAD_BEEF, 32'h1234_5678};
    burst(8'hFE, 9'd4, 0, 3);

    // 3: six-cycle stall after the first word
    exp_addr = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    exp_data = '{32'h3000_0020, 32'h3000_0021, 32'h3000_0022, 32'h3000_0023, 32'h3000_0024};
    burst(8'h20, 9'd5, 6, 0);

    // 4: empty burst
    exp_addr = {};
    exp_data = {};
    burst(8'h33, 9'd0, 0, 0);
`ifdef CHECKSUM_EN
    check("empty_csum", burst_csum, 0);
`endif

    // 5: reset during an 8-word burst after two words delivered
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_base = 8'h50; cmd_len = 9'd8; out_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    hs = 0;
    for (int k = 0; k < 20 && hs < 2; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) hs++;
    end
    check("reset_mid_hs_reached", hs, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold_done", done, 0);
    check("reset_hold_valid", out_valid, 0);
    rst_n = 1'b1;
    exp_addr = '{8'h40, 8'h41};
    exp_data = '{32'h4444_0040, 32'h4444_0041};
    burst(8'h40, 9'd2, 0, 0);

`ifdef CHECKSUM_EN
    // 6: checksum of two words, held after done
    exp_addr = '{8'h30, 8'h31};
    exp_data = '{32'h0F0F_0F0F, 32'h00FF_00FF};
    burst(8'h30, 9'd2, 0, 0);
    check("burst_csum", burst_csum, 32'h0FF0_0FF0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
